// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller for one single-port, latency-1 SRAM cut driving its A_BIST_* port group.
// Optional feature macro SRAM_BIST_ERR_CNT_EN adds err_cnt_o, a saturating per-run miscompare counter.
module sram_bist_ctrl #(
  parameter int unsigned          AddrWidth = 6,
  parameter int unsigned          DataWidth = 64,
  parameter logic [DataWidth-1:0] DataBg    = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic [2:0]           fail_elem_o,
  output logic                 bist_en_o,
  output logic                 bist_men_o,
  output logic                 bist_wen_o,
  output logic                 bist_ren_o,
  output logic [AddrWidth-1:0] bist_addr_o,
  output logic [DataWidth-1:0] bist_din_o,
  output logic [DataWidth-1:0] bist_bm_o,
`ifdef SRAM_BIST_ERR_CNT_EN
  output logic [15:0]          err_cnt_o,
`endif
  input  logic [DataWidth-1:0] bist_dout_i
);

  localparam int unsigned          ElemW    = 3;
  localparam logic [ElemW-1:0]     LastElem = 3'd5;
  localparam logic [AddrWidth-1:0] AddrMax  = {AddrWidth{1'b1}};
  localparam logic [AddrWidth-1:0] AddrZero = {AddrWidth{1'b0}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // Element properties: direction, read/write pairing and data polarity.
  function automatic logic elem_down(input logic [ElemW-1:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction
  function automatic logic elem_rw(input logic [ElemW-1:0] e);
    return (e != 3'd0) && (e != LastElem);
  endfunction
  function automatic logic wr_inv(input logic [ElemW-1:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction
  function automatic logic rd_inv(input logic [ElemW-1:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  state_e               state_q, state_d;
  logic [ElemW-1:0]     elem_q, elem_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 wph_q, wph_d;
  logic                 busy_q, busy_d, done_q, done_d, en_q, en_d;
  logic                 men_q, men_d, wen_q, wen_d, ren_q, ren_d;
  logic [AddrWidth-1:0] baddr_q, baddr_d;
  logic [DataWidth-1:0] din_q, din_d, bm_q, bm_d;
  logic                 fail_q, fail_d;
  logic [AddrWidth-1:0] fail_addr_q, fail_addr_d;
  logic [ElemW-1:0]     fail_elem_q, fail_elem_d;
  logic                 cmp_vld_q, cmp_vld_d;
  logic [DataWidth-1:0] exp_q, exp_d;
  logic [AddrWidth-1:0] cmp_addr_q, cmp_addr_d;
  logic [ElemW-1:0]     cmp_elem_q, cmp_elem_d;
  logic                 start_c, mis_c, op_c;

  // Op sequencer; the (elem, addr, wph) pointer names the op currently on the bus.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    wph_d       = wph_q;
    start_c     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          start_c = 1'b1;
          state_d = RUN;
          elem_d  = '0;
          addr_d  = AddrZero;
          wph_d   = 1'b1;
        end
      end
      RUN: begin
        if (!wph_q && elem_rw(elem_q)) begin
          wph_d = 1'b1;
        end else if (addr_q == (elem_down(elem_q) ? AddrZero : AddrMax)) begin
          if (elem_q == LastElem) begin
            state_d = DRAIN;
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = elem_down(elem_d) ? AddrMax : AddrZero;
            wph_d  = 1'b0;
          end
        end else begin
          addr_d = elem_down(elem_q) ? addr_q - AddrWidth'(1) : addr_q + AddrWidth'(1);
          wph_d  = (elem_q == 3'd0);
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    op_c    = (state_d == RUN);
    busy_d  = (state_d == RUN) || (state_d == DRAIN);
    en_d    = busy_d;
    done_d  = (state_d == DONE);
    men_d   = op_c;
    wen_d   = op_c && wph_d;
    ren_d   = op_c && !wph_d;
    baddr_d = op_c ? addr_d : AddrZero;
    din_d   = wen_d ? (wr_inv(elem_d) ? ~DataBg : DataBg) : '0;
    bm_d    = wen_d ? {DataWidth{1'b1}} : '0;

    // Read issued this cycle: its expectation is checked against dout next cycle.
    cmp_vld_d  = ren_q;
    exp_d      = rd_inv(elem_q) ? ~DataBg : DataBg;
    cmp_addr_d = addr_q;
    cmp_elem_d = elem_q;
    mis_c      = cmp_vld_q && (bist_dout_i != exp_q);

    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    if (start_c) begin
      fail_d      = 1'b0;
      fail_addr_d = AddrZero;
      fail_elem_d = '0;
    end else if (mis_c && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = cmp_addr_q;
      fail_elem_d = cmp_elem_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      addr_q      <= AddrZero;
      wph_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      baddr_q     <= AddrZero;
      din_q       <= '0;
      bm_q        <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= AddrZero;
      fail_elem_q <= '0;
      cmp_vld_q   <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= AddrZero;
      cmp_elem_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      wph_q       <= wph_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      en_q        <= en_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      baddr_q     <= baddr_d;
      din_q       <= din_d;
      bm_q        <= bm_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      cmp_vld_q   <= cmp_vld_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
    end
  end

`ifdef SRAM_BIST_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Counts every miscompared read of the run, saturating.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (start_c) begin
      err_cnt_d = '0;
    end else if (mis_c && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign bist_en_o   = en_q;
  assign bist_men_o  = men_q;
  assign bist_wen_o  = wen_q;
  assign bist_ren_o  = ren_q;
  assign bist_addr_o = baddr_q;
  assign bist_din_o  = din_q;
  assign bist_bm_o   = bm_q;

endmodule
